// File: rtl/input_conditioner.sv
// input_conditioner: debounces the synchronized sensor, walk and reprogram inputs.
// Delivers a clean sensor level, a sticky walk request and a one-cycle reprogram pulse, all registered.
module input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic Reset,
   input  logic Sensor_Sync,
   input  logic WR_Sync,
   input  logic Reprog_Sync,
   input  logic Walk_Ack,
   output logic Sensor_Stable,
   output logic Walk_Pending,
   output logic Reprog_Pulse
);

   localparam int         NCH        = 3;
   localparam int         CH_SENSOR  = 0;
   localparam int         CH_WALK    = 1;
   localparam int         CH_REPROG  = 2;
   localparam logic [7:0] CNT_LAST   = 8'(DEBOUNCE_CYCLES - 1);

   logic [NCH-1:0] sync_in;
   logic [NCH-1:0] stable_q;
   logic [NCH-1:0] stable_d;
   logic [NCH-1:0] rise;
   logic [7:0]     cnt_q [NCH];
   logic [7:0]     cnt_d [NCH];
   logic           walk_pending_q;
   logic           walk_pending_d;
   logic           reprog_pulse_q;
   logic           reprog_pulse_d;

   assign sync_in = {Reprog_Sync, WR_Sync, Sensor_Sync};

   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         stable_d[i] = stable_q[i];
         cnt_d[i]    = 8'd0;
         // Any sample that agrees with the accepted level restarts the count.
         if (sync_in[i] != stable_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
               stable_d[i] = sync_in[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 8'd1;
            end
         end
      end
      rise           = stable_d & ~stable_q;
      // A new request on the same edge as an acknowledge must survive.
      walk_pending_d = rise[CH_WALK] | (walk_pending_q & ~Walk_Ack);
      reprog_pulse_d = rise[CH_REPROG];
   end

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         stable_q       <= '0;
         walk_pending_q <= 1'b0;
         reprog_pulse_q <= 1'b0;
         for (int i = 0; i < NCH; i++) begin
            cnt_q[i] <= 8'd0;
         end
      end else begin
         stable_q       <= stable_d;
         walk_pending_q <= walk_pending_d;
         reprog_pulse_q <= reprog_pulse_d;
         for (int i = 0; i < NCH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign Sensor_Stable = stable_q[CH_SENSOR];
   assign Walk_Pending  = walk_pending_q;
   assign Reprog_Pulse  = reprog_pulse_q;

endmodule
